// File: rtl/register_file_pkg.sv
// Shared constants and types for the register file, writeback mux and controller.
package register_file_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [AW-1:0]    reg_idx_t;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [NREGS-1:0] reg_mask_t;

    // One-hot select of a register index.
    function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
        idx_onehot = reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write/reserve/read bus between the datapath controller (master) and the register file (slave).
interface register_file_if;
    import register_file_pkg::*;

    word_t     data_in;
    reg_idx_t  writenum;
    logic      write;
    logic      reserve;
    reg_idx_t  reservenum;
    reg_idx_t  readnum_a;
    reg_idx_t  readnum_b;
    word_t     data_out_a;
    word_t     data_out_b;
    logic      pending_a;
    logic      pending_b;
    reg_mask_t pending_vec;
    logic [7:0] wr_count;

    modport master (
        output data_in, writenum, write, reserve, reservenum, readnum_a, readnum_b,
        input  data_out_a, data_out_b, pending_a, pending_b, pending_vec, wr_count
    );

    modport slave (
        input  data_in, writenum, write, reserve, reservenum, readnum_a, readnum_b,
        output data_out_a, data_out_b, pending_a, pending_b, pending_vec, wr_count
    );

endinterface

// File: rtl/regfile_reg.sv
// Load-enabled W-bit register with asynchronous active-high reset.
module regfile_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/register_file.sv
// 8x16 register file with two combinational read ports and a pending-write scoreboard.
// Optional same-cycle write-through forwarding when REGFILE_BYPASS_EN is defined.
module register_file
    import register_file_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);

    word_t      regs [NREGS];
    reg_mask_t  load_c;
    reg_mask_t  pending;
    reg_mask_t  pending_nxt_c;
    logic [7:0] wr_count;

    assign load_c = bus.write ? idx_onehot(bus.writenum) : '0;

    for (genvar i = 0; i < int'(NREGS); i++) begin : g_reg
        regfile_reg #(.W(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (load_c[i]),
            .d     (bus.data_in),
            .q     (regs[i])
        );
    end

    // Retiring write clears the bit; a same-index reserve re-sets it afterwards.
    always_comb begin
        pending_nxt_c = pending;
        if (bus.write)   pending_nxt_c = pending_nxt_c & ~idx_onehot(bus.writenum);
        if (bus.reserve) pending_nxt_c = pending_nxt_c |  idx_onehot(bus.reservenum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            wr_count <= '0;
        end else begin
            pending <= pending_nxt_c;
            if (bus.write) wr_count <= wr_count + 8'd1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a_c;
    logic fwd_b_c;
    logic rsv_a_c;
    logic rsv_b_c;

    // Forwarding is suppressed during reset so reads stay at zero.
    assign fwd_a_c = bus.write && !reset && (bus.writenum == bus.readnum_a);
    assign fwd_b_c = bus.write && !reset && (bus.writenum == bus.readnum_b);
    assign rsv_a_c = bus.reserve && (bus.reservenum == bus.readnum_a);
    assign rsv_b_c = bus.reserve && (bus.reservenum == bus.readnum_b);

    assign bus.data_out_a = fwd_a_c ? bus.data_in : regs[bus.readnum_a];
    assign bus.data_out_b = fwd_b_c ? bus.data_in : regs[bus.readnum_b];
    assign bus.pending_a  = fwd_a_c ? rsv_a_c     : pending[bus.readnum_a];
    assign bus.pending_b  = fwd_b_c ? rsv_b_c     : pending[bus.readnum_b];
`else
    assign bus.data_out_a = regs[bus.readnum_a];
    assign bus.data_out_b = regs[bus.readnum_b];
    assign bus.pending_a  = pending[bus.readnum_a];
    assign bus.pending_b  = pending[bus.readnum_b];
`endif

    assign bus.pending_vec = pending;
    assign bus.wr_count    = wr_count;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (honours REGFILE_BYPASS_EN).
module tb_register_file;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    register_file_if bus();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] BYP_EXP = 16'h5A5A;
`else
    localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drive one edge worth of write/reserve, then return 1 time unit after the edge.
    task automatic op(input logic wr, input logic [2:0] widx, input logic [15:0] wdata,
                      input logic rs, input logic [2:0] ridx);
        @(negedge clk);
        bus.write      = wr;
        bus.writenum   = widx;
        bus.data_in    = wdata;
        bus.reserve    = rs;
        bus.reservenum = ridx;
        @(posedge clk);
        #1;
        bus.write   = 1'b0;
        bus.reserve = 1'b0;
    endtask

    task automatic read_a(input logic [2:0] idx, input string tag, input logic [15:0] exp);
        bus.readnum_a = idx;
        #1;
        check(tag, 32'(bus.data_out_a), 32'(exp));
    endtask

    logic [15:0] exp_regs [8];

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.write = 1'b0;
        bus.reserve = 1'b0;
        bus.writenum = '0;
        bus.reservenum = '0;
        bus.data_in = '0;
        bus.readnum_a = '0;
        bus.readnum_b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_vec", 32'(bus.pending_vec), 32'h00);
        check("rst_cnt", 32'(bus.wr_count), 32'd0);
        check("rst_a",   32'(bus.data_out_a), 32'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Same-cycle read of a register being written.
        @(negedge clk);
        bus.write = 1'b1; bus.writenum = 3'd4; bus.data_in = 16'h5A5A; bus.readnum_a = 3'd4;
        #1;
        check("byp_data", 32'(bus.data_out_a), 32'(BYP_EXP));
        check("byp_pend", 32'(bus.pending_a), 32'd0);
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        read_a(3'd4, "byp_after", 16'h5A5A);
        check("byp_cnt", 32'(bus.wr_count), 32'd1);

        // Both ports on the same register; all others untouched.
        op(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
        bus.readnum_a = 3'd5; bus.readnum_b = 3'd5;
        #1;
        check("wr5_a", 32'(bus.data_out_a), 32'hBEEF);
        check("wr5_b", 32'(bus.data_out_b), 32'hBEEF);
        exp_regs = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h5A5A, 16'hBEEF, 16'h0, 16'h0};
        for (int i = 0; i < 8; i++) read_a(3'(i), "others", exp_regs[i]);
        check("wr5_cnt", 32'(bus.wr_count), 32'd2);

        // Scoreboard reserve then retire.
        op(1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
        check("rsv2_vec", 32'(bus.pending_vec), 32'h04);
        bus.readnum_b = 3'd2;
        #1;
        check("rsv2_pb", 32'(bus.pending_b), 32'd1);
        op(1'b1, 3'd2, 16'h0007, 1'b0, 3'd0);
        check("ret2_vec", 32'(bus.pending_vec), 32'h00);
        check("ret2_cnt", 32'(bus.wr_count), 32'd3);
        read_a(3'd2, "ret2_data", 16'h0007);

        // Double reserve stays set.
        op(1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
        op(1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
        check("rsv3x2", 32'(bus.pending_vec), 32'h08);

        // Same-index collision: reserve wins.
        op(1'b1, 3'd6, 16'h00AA, 1'b1, 3'd6);
        read_a(3'd6, "col_data", 16'h00AA);
        check("col_vec", 32'(bus.pending_vec), 32'h48);
        check("col_cnt", 32'(bus.wr_count), 32'd4);

        // Different indices: both effects.
        op(1'b1, 3'd6, 16'h00BB, 1'b1, 3'd1);
        check("diff_vec", 32'(bus.pending_vec), 32'h0A);
        read_a(3'd6, "diff_data", 16'h00BB);

        // Non-pending write and R0 writable.
        op(1'b1, 3'd7, 16'h1111, 1'b0, 3'd0);
        check("np_vec", 32'(bus.pending_vec), 32'h0A);
        check("np_cnt", 32'(bus.wr_count), 32'd6);
        op(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0);
        read_a(3'd0, "r0_data", 16'hFFFF);

        // Asynchronous reset mid-operation.
        op(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
        read_a(3'd3, "pre_rst", 16'h1234);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_a",   32'(bus.data_out_a), 32'h0000);
        check("arst_vec", 32'(bus.pending_vec), 32'h00);
        check("arst_cnt", 32'(bus.wr_count), 32'd0);
        bus.write = 1'b1; bus.writenum = 3'd3; bus.data_in = 16'h9999;
        bus.reserve = 1'b1; bus.reservenum = 3'd3;
        @(posedge clk);
        #1;
        check("rst_drop_a",   32'(bus.data_out_a), 32'h0000);
        check("rst_drop_vec", 32'(bus.pending_vec), 32'h00);
        check("rst_drop_cnt", 32'(bus.wr_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.reserve = 1'b0;
        bus.data_in = 16'h55AA;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        read_a(3'd3, "post_rst", 16'h55AA);
        check("post_rst_cnt", 32'(bus.wr_count), 32'd1);

        // Counter wrap from zero over 256 writes.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 255; i++) op(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0);
        check("cnt_255", 32'(bus.wr_count), 32'd255);
        op(1'b1, 3'd7, 16'h10FF, 1'b0, 3'd0);
        check("cnt_wrap", 32'(bus.wr_count), 32'd0);
        read_a(3'd7, "wrap_last", 16'h10FF);
        read_a(3'd0, "wrap_r0",   16'h10F8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
